// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Bytes arrive over a valid/ready handshake, are buffered, and are sent
// as 8N1 (or 8E1 when PARITY_EN=1) at a runtime-programmable bit period.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY_EN  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_en_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 par_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic [7:0]           head;

    assign full         = (level == FULL_LEVEL);
    assign empty        = (level == '0);
    assign tx_ready_o   = !full && !rst;
    assign push         = tx_valid_i && tx_ready_o;
    assign bit_end      = (cnt == div_q);
    assign head         = mem[rd_ptr];
    assign fifo_level_o = level;

    // A byte leaves the FIFO either from IDLE or at the last cycle of a stop bit.
    assign pop = !empty && cfg_en_i &&
                 ((state == IDLE) || ((state == STOP) && bit_end));

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Frame sequencer; a pop always starts a new frame, whichever state issued it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            div_q   <= '0;
            par_q   <= 1'b0;
        end else if (pop) begin
            shreg   <= head;
            par_q   <= ^head;
            div_q   <= cfg_div_i;
            cnt     <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            state   <= START;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx_o  <= shreg[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx_o  <= par_q;
                                state <= PARITY;
                            end else begin
                                tx_o  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_o    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx_o  <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one 8N1 and one 8E1 instance share stimulus; each
// has a line monitor that decodes frames and checks them against a queue of
// expected bytes pushed by the stimulus.
module tb_uart_tx_fifo;

    typedef struct {
        logic [7:0]  d;
        int unsigned div;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        ready0, ready1;
    logic        tx0, tx1;
    logic        busy0, busy1;
    logic [4:0]  level0, level1;
    logic [1:0]  line;
    logic [1:0]  busy;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    int   b2b [2];
    exp_t q0 [$];
    exp_t q1 [$];

    assign line = {tx1, tx0};
    assign busy = {busy1, busy0};

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(ready0),
        .tx_o(tx0), .busy_o(busy0), .fifo_level_o(level0)
    );

    uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(ready1),
        .tx_o(tx1), .busy_o(busy1), .fifo_level_o(level1)
    );

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line level of bit slot b of a UART frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int b, input bit par);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par && b == 9) return ^d;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            exp_t e;
            int   idle;
            int   bad;
            int   nbits;
            bit   ended;
            bit   aborted;
            bit   has;
            idle  = 1;
            ended = 1'b0;
            forever begin
                @(negedge clk);
                if (!mon_en) begin
                    idle  = 1;
                    ended = 1'b0;
                end else if (line[g] == 1'b0) begin
                    has = (g == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    check_eq($sformatf("dut%0d_frame_expected", g), int'(has), 1);
                    if (has) begin
                        if (g == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if (idle == 0) b2b[g]++;
                        nbits   = (g == 1) ? 11 : 10;
                        aborted = 1'b0;
                        for (int b = 0; b < nbits && !aborted; b++) begin
                            bad = 0;
                            for (int c = 0; c <= int'(e.div); c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (!mon_en) begin
                                    aborted = 1'b1;
                                    break;
                                end
                                if (line[g] !== frame_bit(e.d, b, g == 1) || busy[g] !== 1'b1) bad++;
                            end
                            if (!aborted)
                                check_eq($sformatf("dut%0d_byte%02h_slot%0d_bad_cycles", g, e.d, b), bad, 0);
                        end
                        ended = !aborted;
                    end
                    idle = 0;
                end else begin
                    if (ended) check_eq($sformatf("dut%0d_busy_after_frame", g), int'(busy[g]), 0);
                    ended = 1'b0;
                    idle++;
                end
            end
        end
    end

    task automatic expect_byte(input logic [7:0] d, input int unsigned div);
        exp_t e;
        e.d   = d;
        e.div = div;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic push(input logic [7:0] d, input int unsigned div);
        int n = 0;
        @(negedge clk);
        while (!(ready0 && ready1)) begin
            n++;
            if (n > 20000) begin
                check_eq("push_ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        expect_byte(d, div);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && busy0 == 1'b0 && busy1 == 1'b0 &&
                     tx0 && tx1 && level0 == '0 && level1 == '0) && n < budget);
        check_eq("wait_idle_in_budget", int'(n < budget), 1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_tx0"}, int'(tx0), 1);
        check_eq({tag, "_tx1"}, int'(tx1), 1);
        check_eq({tag, "_busy0"}, int'(busy0), 0);
        check_eq({tag, "_busy1"}, int'(busy1), 0);
        check_eq({tag, "_level0"}, int'(level0), 0);
        check_eq({tag, "_level1"}, int'(level1), 0);
    endtask

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, cnt0, cnt1, n;
        logic [7:0] hello [6];
        rst      = 1'b1;
        cfg_en   = 1'b0;
        cfg_div  = 16'd3;
        tx_data  = '0;
        tx_valid = 1'b0;
        b2b[0]   = 0;
        b2b[1]   = 0;

        @(negedge clk);
        check_eq("ready_in_reset0", int'(ready0), 0);
        check_eq("ready_in_reset1", int'(ready1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("reset");
        check_eq("ready_after_reset0", int'(ready0), 1);
        check_eq("ready_after_reset1", int'(ready1), 1);

        // 0x55 at 4 cycles/bit: start latency and busy length
        mon_en = 1'b1;
        cfg_en = 1'b1;
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        expect_byte(8'h55, 3);
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("line_high_at_push_cycle", int'(tx0), 1);
        @(negedge clk);
        check_eq("start_latency_dut0", int'(tx0), 0);
        check_eq("start_latency_dut1", int'(tx1), 0);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            cnt0 += int'(busy0);
            cnt1 += int'(busy1);
        end
        check_eq("busy_cycles_8n1", cnt0, 40);
        check_eq("busy_cycles_8e1", cnt1, 44);
        wait_idle(500);

        // Two queued bytes go out back to back; parity bits 1 then 0
        cfg_en = 1'b0;
        b0 = b2b[0];
        b1 = b2b[1];
        push(8'h07, 3);
        push(8'h03, 3);
        cfg_en = 1'b1;
        wait_idle(500);
        check_eq("b2b_pair_dut0", b2b[0] - b0, 1);
        check_eq("b2b_pair_dut1", b2b[1] - b1, 1);

        // Fill to capacity while disabled, then drain
        cfg_en = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), 3);
        @(negedge clk);
        check_eq("full_level0", int'(level0), 16);
        check_eq("full_level1", int'(level1), 16);
        check_eq("full_ready0", int'(ready0), 0);
        check_eq("full_ready1", int'(ready1), 0);
        tx_data  = 8'h10;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("overflow_ignored_level0", int'(level0), 16);
        b0 = b2b[0];
        b1 = b2b[1];
        cfg_en = 1'b1;
        @(negedge clk);
        check_eq("first_pop_level0", int'(level0), 15);
        check_eq("first_pop_ready0", int'(ready0), 1);
        check_eq("first_pop_ready1", int'(ready1), 1);
        wait_idle(2000);
        check_eq("b2b_drain_dut0", b2b[0] - b0, 15);
        check_eq("b2b_drain_dut1", b2b[1] - b1, 15);

        // Divisor change mid-frame applies to the next frame only
        cfg_en = 1'b0;
        push(8'hC3, 3);
        push(8'h5A, 7);
        cfg_en = 1'b1;
        repeat (12) @(negedge clk);
        cfg_div = 16'd7;
        wait_idle(1000);
        cfg_div = 16'd3;

        // Reset during data bit 4 aborts the frame
        mon_en = 1'b0;
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_frame_started", int'(tx0), 0);
        repeat (21) @(negedge clk);
        check_eq("abort_in_frame_busy0", int'(busy0), 1);
        rst = 1'b1;
        #1;
        check_eq("midframe_rst_ready0", int'(ready0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("midframe_rst");
        check_eq("post_rst_ready0", int'(ready0), 1);
        mon_en = 1'b1;
        push(8'h3C, 3);
        wait_idle(500);

        // Random traffic with enable toggling and per-batch divisor
        for (int batch = 0; batch < 3; batch++) begin
            cfg_div = 16'($urandom_range(0, 3));
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 3) == 0) cfg_en = ~cfg_en;
                repeat ($urandom_range(0, 20)) @(negedge clk);
                push(8'($urandom), int'(cfg_div));
            end
            cfg_en = 1'b1;
            wait_idle(5000);
        end

        // Real baud rate: 100 MHz / 868 ~ 115200
        cfg_div  = 16'd867;
        cfg_en   = 1'b1;
        hello[0] = "H";
        hello[1] = "e";
        hello[2] = "l";
        hello[3] = "l";
        hello[4] = "o";
        hello[5] = 8'h0A;
        for (int i = 0; i < 6; i++) push(hello[i], 867);
        wait_idle(62000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
